// File: rtl/traffic_pkg.sv
// Shared state codes, lamp bit positions and BCD helpers for the intersection phase scheduler.
// Pure declarations: no latency and no flow control.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } phase_e;

  localparam int LAMP_NS_RED = 5;
  localparam int LAMP_NS_YEL = 4;
  localparam int LAMP_NS_GRN = 3;
  localparam int LAMP_EW_RED = 2;
  localparam int LAMP_EW_YEL = 1;
  localparam int LAMP_EW_GRN = 0;

  typedef logic [5:0] lamps_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Only ever evaluated on parameters, so the divide folds away at elaboration.
  function automatic bcd2_t to_bcd2(input int unsigned val);
    bcd2_t r;
    r.tens = 4'(val / 10);
    r.ones = 4'(val % 10);
    return r;
  endfunction

  function automatic lamps_t lamps_for(input phase_e st, input logic flash_bit);
    lamps_t l;
    l = '0;
    case (st)
      NS_GREEN:  begin l[LAMP_NS_GRN] = 1'b1; l[LAMP_EW_RED] = 1'b1; end
      NS_YELLOW: begin l[LAMP_NS_YEL] = 1'b1; l[LAMP_EW_RED] = 1'b1; end
      ALLRED_A,
      ALLRED_B:  begin l[LAMP_NS_RED] = 1'b1; l[LAMP_EW_RED] = 1'b1; end
      EW_GREEN:  begin l[LAMP_EW_GRN] = 1'b1; l[LAMP_NS_RED] = 1'b1; end
      EW_YELLOW: begin l[LAMP_EW_YEL] = 1'b1; l[LAMP_NS_RED] = 1'b1; end
      FLASH:     begin l[LAMP_NS_YEL] = flash_bit; l[LAMP_EW_YEL] = flash_bit; end
      default:   begin l[LAMP_NS_GRN] = 1'b1; l[LAMP_EW_RED] = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with parallel load; load has priority over decrement.
// Latency: 1 CLK from load/dec to digits; no backpressure, is_one is combinational from the digits.
module bcd_down_counter
  import traffic_pkg::*;
#(
  parameter bcd2_t RST_VAL = '0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       load,
  input  bcd2_t      load_val,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       is_one
);

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      tens <= RST_VAL.tens;
      ones <= RST_VAL.ones;
    end else if (load) begin
      tens <= load_val.tens;
      ones <= load_val.ones;
    end else if (dec) begin
      if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

  assign is_one = (tens == 4'd0) && (ones == 4'd1);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// NS/EW phase scheduler with 1 s prescaler, BCD countdown, pedestrian truncation and night flash.
// Latency: registered lamps/digits change on the edge closing a tick cycle; free-running, no backpressure.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int GREEN_S     = 25,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 2,
  parameter int MIN_GREEN_S = 5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       ped_req,
  input  logic       night,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] phase,
  output logic       ped_pending
);

  localparam int             PW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST      = PW'(TICK_DIV - 1);
  localparam bcd2_t          GREEN_BCD     = to_bcd2(GREEN_S);
  localparam bcd2_t          YELLOW_BCD    = to_bcd2(YELLOW_S);
  localparam bcd2_t          ALLRED_BCD    = to_bcd2(ALLRED_S);
  localparam bcd2_t          MIN_GREEN_BCD = to_bcd2(MIN_GREEN_S);
  localparam bcd2_t          ZERO_BCD      = '0;
  localparam logic [7:0]     MIN_GREEN_BIN = 8'(MIN_GREEN_S);

  logic [PW-1:0] prescaler;
  logic          tick;
  phase_e        state;
  phase_e        nxt_state;
  logic          flash_bit;
  logic          nxt_flash;
  lamps_t        lamps;
  logic          ped_prev;
  logic          ped_armed;
  logic          ped_rise;
  logic          ped_clear;
  logic          entering_clear;
  logic          illegal;
  logic          in_green;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_is_one;
  bcd2_t         cnt_load_val;
  logic [7:0]    cnt_bin;

  assign tick     = (prescaler == PRE_LAST);
  assign illegal  = (3'(state) == 3'd7);
  assign in_green = (state == NS_GREEN) || (state == EW_GREEN);
  assign ped_rise = ped_req && !ped_prev;
  assign cnt_bin  = ({4'd0, sec_tens} * 8'd10) + {4'd0, sec_ones};

  always_ff @(posedge CLK) begin
    if (!CLR || tick) prescaler <= '0;
    else              prescaler <= prescaler + PW'(1);
  end

  always_comb begin
    nxt_state    = state;
    nxt_flash    = flash_bit;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = GREEN_BCD;
    if (illegal) begin
      nxt_state = NS_GREEN;
      nxt_flash = 1'b0;
      cnt_load  = 1'b1;
    end else if (tick) begin
      if (state == FLASH) begin
        if (night) begin
          nxt_flash = !flash_bit;
        end else begin
          nxt_state    = ALLRED_B;
          nxt_flash    = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = ALLRED_BCD;
        end
      end else if (night) begin
        nxt_state    = FLASH;
        nxt_flash    = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = ZERO_BCD;
      end else if (cnt_is_one) begin
        cnt_load = 1'b1;
        case (state)
          NS_GREEN:  begin nxt_state = NS_YELLOW; cnt_load_val = YELLOW_BCD; end
          NS_YELLOW: begin nxt_state = ALLRED_A;  cnt_load_val = ALLRED_BCD; end
          ALLRED_A:  begin nxt_state = EW_GREEN;  cnt_load_val = GREEN_BCD;  end
          EW_GREEN:  begin nxt_state = EW_YELLOW; cnt_load_val = YELLOW_BCD; end
          EW_YELLOW: begin nxt_state = ALLRED_B;  cnt_load_val = ALLRED_BCD; end
          default:   begin nxt_state = NS_GREEN;  cnt_load_val = GREEN_BCD;  end
        endcase
      end else if (in_green && ped_pending && (cnt_bin > MIN_GREEN_BIN)) begin
        cnt_load     = 1'b1;
        cnt_load_val = MIN_GREEN_BCD;
      end else begin
        cnt_dec = 1'b1;
      end
    end
  end

  // A request only counts as served once it has been pending during a green; one raised
  // in yellow/all-red/flash must survive the next all-red entry to reach the next green.
  assign entering_clear = (nxt_state != state) &&
                          ((nxt_state == ALLRED_A) || (nxt_state == ALLRED_B) || (nxt_state == FLASH));
  assign ped_clear      = entering_clear && ((nxt_state == FLASH) || ped_armed);

  always_ff @(posedge CLK) begin
    if (!CLR || illegal) begin
      state       <= NS_GREEN;
      flash_bit   <= 1'b0;
      lamps       <= lamps_for(NS_GREEN, 1'b0);
      ped_prev    <= 1'b0;
      ped_pending <= 1'b0;
      ped_armed   <= 1'b0;
    end else begin
      state     <= nxt_state;
      flash_bit <= nxt_flash;
      lamps     <= lamps_for(nxt_state, nxt_flash);
      ped_prev  <= ped_req;
      if (ped_clear) begin
        ped_pending <= 1'b0;
        ped_armed   <= 1'b0;
      end else begin
        if (ped_rise)                ped_pending <= 1'b1;
        if (ped_pending && in_green) ped_armed   <= 1'b1;
      end
    end
  end

  bcd_down_counter #(
    .RST_VAL (GREEN_BCD)
  ) u_cnt (
    .CLK      (CLK),
    .CLR      (CLR),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .tens     (sec_tens),
    .ones     (sec_ones),
    .is_one   (cnt_is_one)
  );

  assign ns_red    = lamps[LAMP_NS_RED];
  assign ns_yellow = lamps[LAMP_NS_YEL];
  assign ns_green  = lamps[LAMP_NS_GRN];
  assign ew_red    = lamps[LAMP_EW_RED];
  assign ew_yellow = lamps[LAMP_EW_YEL];
  assign ew_green  = lamps[LAMP_EW_GRN];
  assign phase     = 3'(state);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: tick-by-tick vector tables plus hand sequences for reset spacing.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       ped_req = 1'b0;
  logic       night = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [3:0] sec_tens, sec_ones;
  logic [2:0] phase;
  logic       ped_pending;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  traffic_phase_ctrl #(
    .TICK_DIV    (4),
    .GREEN_S     (12),
    .YELLOW_S    (3),
    .ALLRED_S    (2),
    .MIN_GREEN_S (5)
  ) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .ped_req     (ped_req),
    .night       (night),
    .ns_red      (ns_red),
    .ns_yellow   (ns_yellow),
    .ns_green    (ns_green),
    .ew_red      (ew_red),
    .ew_yellow   (ew_yellow),
    .ew_green    (ew_green),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .phase       (phase),
    .ped_pending (ped_pending)
  );

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  localparam logic [5:0] L_NSG = 6'b001100;
  localparam logic [5:0] L_NSY = 6'b010100;
  localparam logic [5:0] L_AR  = 6'b100100;
  localparam logic [5:0] L_EWG = 6'b100001;
  localparam logic [5:0] L_EWY = 6'b100010;
  localparam logic [5:0] L_FL1 = 6'b010010;
  localparam logic [5:0] L_OFF = 6'b000000;

  wire [5:0] lamps_obs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
  wire [7:0] cnt_obs   = {sec_tens, sec_ones};

  typedef struct packed {
    logic       ped;
    logic       night;
    logic [2:0] ph;
    logic [7:0] cnt;
    logic [5:0] lamps;
    logic       pend;
  } vec_t;

  vec_t fr[$];
  vec_t hv[$];

  function automatic vec_t mk(input logic p, input logic n, input logic [2:0] ph,
                              input logic [7:0] cnt, input logic [5:0] l, input logic pend);
    vec_t v;
    v.ped = p; v.night = n; v.ph = ph; v.cnt = cnt; v.lamps = l; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(input string name, input int idx, input vec_t v);
    chk({name, ".phase"}, idx, 32'(phase), 32'(v.ph));
    chk({name, ".cnt"},   idx, 32'(cnt_obs), 32'(v.cnt));
    chk({name, ".lamps"}, idx, 32'(lamps_obs), 32'(v.lamps));
    chk({name, ".pend"},  idx, 32'(ped_pending), 32'(v.pend));
  endtask

  // Inputs applied at a negedge, then exactly one tick period (4 CLK) elapses before sampling.
  task automatic apply_vec(input string name, input int idx, input vec_t v);
    night = v.night;
    if (v.ped) begin
      ped_req = 1'b1;
      @(negedge CLK);
      ped_req = 1'b0;
      repeat (3) @(negedge CLK);
    end else begin
      repeat (4) @(negedge CLK);
    end
    chk_all(name, idx, v);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b0; ped_req = 1'b0; night = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
  endtask

  task automatic run_fr(input string name, input int n);
    for (int i = 1; i <= n; i++) apply_vec(name, i, fr[i]);
  endtask

  task automatic run_hv(input string name, input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply_vec(name, i - lo, hv[i]);
  endtask

  // Reset state check plus the 3-cycle/4-cycle spacing of the first tick.
  task automatic chk_reset_and_spacing(input string name);
    chk_all(name, 0, mk(0, 0, 3'd0, 8'h12, L_NSG, 0));
    repeat (3) @(negedge CLK);
    chk({name, ".pre_tick_cnt"}, 0, 32'(cnt_obs), 32'h12);
    @(negedge CLK);
    chk({name, ".first_tick_cnt"}, 0, 32'(cnt_obs), 32'h11);
  endtask

  int s3, s4a, s4b, s5, s_end;

  initial begin
    int dur[6];
    logic [5:0] lph[6];
    dur = '{12, 3, 2, 12, 3, 2};
    lph = '{L_NSG, L_NSY, L_AR, L_EWG, L_EWY, L_AR};
    for (int p = 0; p < 6; p++)
      for (int d = dur[p]; d >= 1; d--)
        fr.push_back(mk(0, 0, 3'(p), 8'(((d / 10) * 16) + (d % 10)), lph[p], 0));

    // Pedestrian pulse at countdown 10 (after two plain ticks).
    s3 = hv.size();
    hv.push_back(mk(1, 0, 3'd0, 8'h05, L_NSG, 1));
    hv.push_back(mk(0, 0, 3'd0, 8'h04, L_NSG, 1));
    hv.push_back(mk(0, 0, 3'd0, 8'h03, L_NSG, 1));
    hv.push_back(mk(0, 0, 3'd0, 8'h02, L_NSG, 1));
    hv.push_back(mk(0, 0, 3'd0, 8'h01, L_NSG, 1));
    hv.push_back(mk(0, 0, 3'd1, 8'h03, L_NSY, 1));
    hv.push_back(mk(0, 0, 3'd1, 8'h02, L_NSY, 1));
    hv.push_back(mk(0, 0, 3'd1, 8'h01, L_NSY, 1));
    hv.push_back(mk(0, 0, 3'd2, 8'h02, L_AR,  0));
    hv.push_back(mk(0, 0, 3'd2, 8'h01, L_AR,  0));
    hv.push_back(mk(0, 0, 3'd3, 8'h12, L_EWG, 0));
    // Pedestrian pulse at countdown 04: no truncation.
    s4a = hv.size();
    hv.push_back(mk(1, 0, 3'd0, 8'h03, L_NSG, 1));
    hv.push_back(mk(0, 0, 3'd0, 8'h02, L_NSG, 1));
    hv.push_back(mk(0, 0, 3'd0, 8'h01, L_NSG, 1));
    hv.push_back(mk(0, 0, 3'd1, 8'h03, L_NSY, 1));
    hv.push_back(mk(0, 0, 3'd1, 8'h02, L_NSY, 1));
    hv.push_back(mk(0, 0, 3'd1, 8'h01, L_NSY, 1));
    hv.push_back(mk(0, 0, 3'd2, 8'h02, L_AR,  0));
    // Pedestrian pulse during NS_YELLOW, held across ALLRED_A, truncates EW_GREEN.
    s4b = hv.size();
    hv.push_back(mk(1, 0, 3'd1, 8'h02, L_NSY, 1));
    hv.push_back(mk(0, 0, 3'd1, 8'h01, L_NSY, 1));
    hv.push_back(mk(0, 0, 3'd2, 8'h02, L_AR,  1));
    hv.push_back(mk(0, 0, 3'd2, 8'h01, L_AR,  1));
    hv.push_back(mk(0, 0, 3'd3, 8'h12, L_EWG, 1));
    hv.push_back(mk(0, 0, 3'd3, 8'h05, L_EWG, 1));
    hv.push_back(mk(0, 0, 3'd3, 8'h04, L_EWG, 1));
    hv.push_back(mk(0, 0, 3'd3, 8'h03, L_EWG, 1));
    hv.push_back(mk(0, 0, 3'd3, 8'h02, L_EWG, 1));
    hv.push_back(mk(0, 0, 3'd3, 8'h01, L_EWG, 1));
    hv.push_back(mk(0, 0, 3'd4, 8'h03, L_EWY, 1));
    hv.push_back(mk(0, 0, 3'd4, 8'h02, L_EWY, 1));
    hv.push_back(mk(0, 0, 3'd4, 8'h01, L_EWY, 1));
    hv.push_back(mk(0, 0, 3'd5, 8'h02, L_AR,  0));
    hv.push_back(mk(0, 0, 3'd5, 8'h01, L_AR,  0));
    hv.push_back(mk(0, 0, 3'd0, 8'h12, L_NSG, 0));
    // Night mode entered mid EW_GREEN, then released.
    s5 = hv.size();
    hv.push_back(mk(0, 1, 3'd6, 8'h00, L_FL1, 0));
    hv.push_back(mk(0, 1, 3'd6, 8'h00, L_OFF, 0));
    hv.push_back(mk(0, 1, 3'd6, 8'h00, L_FL1, 0));
    hv.push_back(mk(0, 1, 3'd6, 8'h00, L_OFF, 0));
    hv.push_back(mk(0, 0, 3'd5, 8'h02, L_AR,  0));
    hv.push_back(mk(0, 0, 3'd5, 8'h01, L_AR,  0));
    hv.push_back(mk(0, 0, 3'd0, 8'h12, L_NSG, 0));
    s_end = hv.size();

    // Reset, tick spacing and one full 34-tick cycle.
    do_reset();
    chk_reset_and_spacing("reset");
    for (int i = 2; i <= 34; i++) apply_vec("free_run", i, fr[i % 34]);

    do_reset();
    run_fr("ped10_pre", 2);
    run_hv("ped10", s3, s4a);

    do_reset();
    run_fr("ped04_pre", 8);
    run_hv("ped04", s4a, s4b);

    do_reset();
    run_fr("pedy_pre", 12);
    run_hv("ped_yellow", s4b, s5);

    do_reset();
    run_fr("night_pre", 19);
    run_hv("night", s5, s_end);

    // Synchronous reset in the middle of NS_YELLOW with a request pending.
    do_reset();
    run_fr("clr_pre", 13);
    @(negedge CLK);
    ped_req = 1'b1;
    @(negedge CLK);
    ped_req = 1'b0;
    chk("clr_pre.pend", 0, 32'(ped_pending), 32'd1);
    CLR = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    chk_reset_and_spacing("mid_clr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
